pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch sequencer with vectored interrupt entry and return.
- Sits directly upstream of the instruction memory and drives its 4-bit PC address every cycle.
- The instruction memory registers its output, so the instruction for `pc` appears one cycle after `pc` changes.
- Handles sequential fetch, branch redirect, single-level (non-nested) vectored interrupts with saved return PC, and return-from-interrupt.

Parameters:
- PC_W, 4, program counter width; all address arithmetic is modulo 2^PC_W.
- NUM_IRQ, 4, number of interrupt request lines; line 0 has the highest priority.
- VEC_BASE, 12, vector table base; line i vectors to (VEC_BASE + i) mod 2^PC_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  freeze: holds pc and all state; branch, reti and irq acceptance are ignored while high.
- branch_en  input  1  redirect request from the decoder.
- branch_addr  input  PC_W  branch target.
- reti  input  1  return-from-interrupt request.
- irq_en  input  1  global interrupt enable.
- irq_req  input  NUM_IRQ  level-sensitive requests; held by the source until acked.
- pc  output  PC_W  current fetch address, registered; drives the instruction memory.
- irq_ack  output  NUM_IRQ  one-hot, one-cycle pulse for the accepted line.
- in_isr  output  1  high while an interrupt service routine is active.
- saved_pc  output  PC_W  return address captured on interrupt entry.
- redirect  output  1  one-cycle pulse, registered with pc, when pc is non-sequential; the decoder discards the instruction arriving in the following cycle.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high. Only `reset` sampled high at a rising edge takes effect.
- Reset values:
  - pc=RESET_PC, saved_pc=0, irq_ack=0, in_isr=0, redirect=0.
  - State RUN.
  - Reset mid-ISR returns to RUN and drops the saved PC.
- States:
  - RUN: in_isr=0.
  - ISR: in_isr=1.
- Per-edge priority when reset=0 and stall=0:
  1. RUN, irq_en=1, and any irq_req bit set → accept the lowest-index set bit i.
     - saved_pc <= branch_addr if branch_en, else pc+1.
     - pc <= VEC_BASE+i; irq_ack[i]=1; redirect=1; next state ISR.
  2. ISR and reti=1 → pc <= saved_pc; redirect=1; next state RUN. A branch_en in the same cycle is ignored.
  3. branch_en=1 → pc <= branch_addr; redirect=1.
  4. Otherwise → pc <= pc+1; redirect=0.
- In ISR, irq_req is ignored (no nesting); branches inside the ISR work normally.
- reti while in RUN is ignored and treated as absent; the edge falls through to branch or increment.
- Wrap-around: pc=2^PC_W-1 increments to 0. Vector and return addresses wrap the same way.
- stall=1: pc, saved_pc and state hold; irq_ack=0; redirect=0; requests arriving during stall must be re-presented.
- irq_ack and redirect are registered pulses, high for exactly one cycle per event.
- A branch target equal to pc+1 still asserts redirect.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then 20 free-running cycles → pc sequence 0,1,…,15,0,1,2,3; redirect=0 throughout; in_isr=0.
- At pc=5, branch_en=1, branch_addr=9 for one cycle → next pc=9, redirect pulse; following pc=10.
- At pc=3, irq_en=1, irq_req=4'b0110 → pc=13 (line 1), irq_ack=4'b0010 one cycle, saved_pc=4, in_isr=1. Then irq_req=4'b0001 while in ISR → ignored. Then reti → pc=4, in_isr=0, redirect pulse.
- At pc=7, irq_req[0]=1 and branch_en=1, branch_addr=2 in the same cycle → pc=12, saved_pc=2. Later reti together with branch_en=1, branch_addr=8 → pc=2 (reti wins).
- stall=1 for 3 cycles at pc=6 with irq_req[2]=1, branch_en=1, reti=1 → pc stays 6, no ack, no redirect. After stall drops with irq_req still high → pc=14, ack[2]. irq_en=0 variant → sequential fetch, no ack.
- Reset asserted while in ISR at pc=13 → next cycle pc=0, in_isr=0, saved_pc=0. reti in RUN → plain increment, no redirect.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch sequencer for a registered-output instruction memory.
// Handles sequential fetch, branch redirect, single-level vectored interrupts
// with a saved return address, and return-from-interrupt. All outputs are
// registered; nothing combinational reaches an output from an input.
module pc_fetch_ctrl #(
   parameter int PC_W     = 4,
   parameter int NUM_IRQ  = 4,
   parameter int VEC_BASE = 12,
   parameter int RESET_PC = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               branch_en,
   input  logic [PC_W-1:0]    branch_addr,
   input  logic               reti,
   input  logic               irq_en,
   input  logic [NUM_IRQ-1:0] irq_req,
   output logic [PC_W-1:0]    pc,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic               in_isr,
   output logic [PC_W-1:0]    saved_pc,
   output logic               redirect
);

   localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   typedef enum logic {RUN = 1'b0, ISR = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    saved_q, saved_d;
   logic [NUM_IRQ-1:0] ack_q, ack_d;
   logic               red_q, red_d;

   logic               irq_any;
   logic [IDX_W-1:0]   irq_idx;
   logic [PC_W-1:0]    pc_inc;
   logic [PC_W-1:0]    vec_addr;

   // Lowest-index pending request wins; scan downward so the last hit is the smallest index.
   always_comb begin
      irq_any = |irq_req;
      irq_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq_req[i]) irq_idx = IDX_W'(i);
      end
   end

   // Address arithmetic wraps naturally at PC_W bits.
   assign pc_inc   = pc_q + PC_W'(1);
   assign vec_addr = PC_W'(VEC_BASE) + PC_W'(irq_idx);

   // State and datapath registers; reset mid-ISR drops the saved return address.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= PC_W'(RESET_PC);
         saved_q <= '0;
         ack_q   <= '0;
         red_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         saved_q <= saved_d;
         ack_q   <= ack_d;
         red_q   <= red_d;
      end
   end

   // Next-state: irq entry > reti (ISR only) > branch > increment; stall freezes everything.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      saved_d = saved_q;
      ack_d   = '0;
      red_d   = 1'b0;
      if (!stall) begin
         if (state_q == RUN && irq_en && irq_any) begin
            // Return to where the interrupted instruction would have gone.
            saved_d = branch_en ? branch_addr : pc_inc;
            pc_d    = vec_addr;
            ack_d   = NUM_IRQ'(1) << irq_idx;
            red_d   = 1'b1;
            state_d = ISR;
         end else if (state_q == ISR && reti) begin
            pc_d    = saved_q;
            red_d   = 1'b1;
            state_d = RUN;
         end else if (branch_en) begin
            // Redirect even if the target happens to equal pc+1.
            pc_d    = branch_addr;
            red_d   = 1'b1;
         end else begin
            pc_d    = pc_inc;
         end
      end
   end

   // Outputs straight from registers.
   always_comb begin
      pc       = pc_q;
      saved_pc = saved_q;
      irq_ack  = ack_q;
      redirect = red_q;
      in_isr   = (state_q == ISR);
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Vector-table bench for pc_fetch_ctrl: each record carries the inputs for one
// clock edge and the outputs expected after it. Expected records go into a
// scoreboard queue when driven and are popped and compared after the edge.
module tb_pc_fetch_ctrl;

   logic       clk = 1'b0;
   logic       reset, stall, branch_en, reti, irq_en;
   logic [3:0] branch_addr, irq_req;
   logic [3:0] pc, irq_ack, saved_pc;
   logic       in_isr, redirect;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       rst, stl, br;
      logic [3:0] ba;
      logic       rt, ie;
      logic [3:0] rq;
      logic [3:0] e_pc, e_ack;
      logic       e_isr;
      logic [3:0] e_sv;
      logic       e_red;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   pc_fetch_ctrl #(.PC_W(4), .NUM_IRQ(4), .VEC_BASE(12), .RESET_PC(0)) dut (
      .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
      .branch_addr(branch_addr), .reti(reti), .irq_en(irq_en), .irq_req(irq_req),
      .pc(pc), .irq_ack(irq_ack), .in_isr(in_isr), .saved_pc(saved_pc),
      .redirect(redirect)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic rst, logic stl, logic br, logic [3:0] ba,
                               logic rt, logic ie, logic [3:0] rq,
                               logic [3:0] e_pc, logic [3:0] e_ack, logic e_isr,
                               logic [3:0] e_sv, logic e_red);
      vec_t v;
      v.rst = rst; v.stl = stl; v.br = br; v.ba = ba; v.rt = rt; v.ie = ie; v.rq = rq;
      v.e_pc = e_pc; v.e_ack = e_ack; v.e_isr = e_isr; v.e_sv = e_sv; v.e_red = e_red;
      return v;
   endfunction

   // Idle edge: no requests, only the expected outputs vary.
   function automatic vec_t idle(logic [3:0] e_pc, logic e_isr, logic [3:0] e_sv);
      return mk(0, 0, 0, 4'd0, 0, 0, 4'd0, e_pc, 4'd0, e_isr, e_sv, 0);
   endfunction

   task automatic step(input vec_t v, input string name);
      vec_t e;
      @(negedge clk);
      reset = v.rst; stall = v.stl; branch_en = v.br; branch_addr = v.ba;
      reti = v.rt; irq_en = v.ie; irq_req = v.rq;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.e_pc || irq_ack !== e.e_ack || in_isr !== e.e_isr ||
          saved_pc !== e.e_sv || redirect !== e.e_red) begin
         failures++;
         $display("FAIL %s: got pc=%0d ack=%b isr=%b saved=%0d red=%b, want pc=%0d ack=%b isr=%b saved=%0d red=%b",
                  name, pc, irq_ack, in_isr, saved_pc, redirect,
                  e.e_pc, e.e_ack, e.e_isr, e.e_sv, e.e_red);
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_addr = 4'd0;
      reti = 1'b0; irq_en = 1'b0; irq_req = 4'd0;

      // rst stl br ba rt ie rq | pc ack isr sv red
      tbl.push_back(mk(1, 0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0));
      // free-running fetch with wrap: 1..15,0,1,2,3
      for (int k = 1; k < 20; k++) tbl.push_back(idle(4'(k % 16), 0, 4'd0));
      tbl.push_back(idle(4'd4, 0, 4'd0));
      tbl.push_back(idle(4'd5, 0, 4'd0));
      // branch at pc=5 to 9, then sequential
      tbl.push_back(mk(0, 0, 1, 4'd9, 0, 0, 4'd0, 4'd9,  4'd0, 0, 4'd0, 1));
      tbl.push_back(idle(4'd10, 0, 4'd0));
      tbl.push_back(mk(0, 0, 1, 4'd3, 0, 0, 4'd0, 4'd3,  4'd0, 0, 4'd0, 1));
      // irq lines 1,2 at pc=3: line 1 wins, vector 13, return 4
      tbl.push_back(mk(0, 0, 0, 4'd0, 0, 1, 4'b0110, 4'd13, 4'b0010, 1, 4'd4, 1));
      // line 0 while in ISR ignored
      tbl.push_back(mk(0, 0, 0, 4'd0, 0, 1, 4'b0001, 4'd14, 4'd0, 1, 4'd4, 0));
      tbl.push_back(mk(0, 0, 0, 4'd0, 1, 0, 4'd0, 4'd4,  4'd0, 0, 4'd4, 1));
      tbl.push_back(idle(4'd5, 0, 4'd4));
      tbl.push_back(mk(0, 0, 1, 4'd7, 0, 0, 4'd0, 4'd7,  4'd0, 0, 4'd4, 1));
      // irq beats branch at pc=7; branch target becomes the return address
      tbl.push_back(mk(0, 0, 1, 4'd2, 0, 1, 4'b0001, 4'd12, 4'b0001, 1, 4'd2, 1));
      // branch inside ISR, then wrap inside ISR
      tbl.push_back(mk(0, 0, 1, 4'd15, 0, 0, 4'd0, 4'd15, 4'd0, 1, 4'd2, 1));
      tbl.push_back(idle(4'd0, 1, 4'd2));
      // reti beats branch
      tbl.push_back(mk(0, 0, 1, 4'd8, 1, 0, 4'd0, 4'd2,  4'd0, 0, 4'd2, 1));
      tbl.push_back(mk(0, 0, 1, 4'd6, 0, 0, 4'd0, 4'd6,  4'd0, 0, 4'd2, 1));
      // stall 3 cycles with everything requested
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(0, 1, 1, 4'd1, 1, 1, 4'b0100, 4'd6, 4'd0, 0, 4'd2, 0));
      // request still held after stall: line 2 -> 14
      tbl.push_back(mk(0, 0, 0, 4'd0, 0, 1, 4'b0100, 4'd14, 4'b0100, 1, 4'd7, 1));
      tbl.push_back(mk(0, 0, 0, 4'd0, 1, 0, 4'd0, 4'd7,  4'd0, 0, 4'd7, 1));
      // irq_en=0: request ignored
      tbl.push_back(mk(0, 0, 0, 4'd0, 0, 0, 4'b0001, 4'd8, 4'd0, 0, 4'd7, 0));
      tbl.push_back(mk(0, 0, 0, 4'd0, 0, 1, 4'b0010, 4'd13, 4'b0010, 1, 4'd9, 1));
      // reset in ISR at pc=13
      tbl.push_back(mk(1, 0, 0, 4'd0, 0, 0, 4'd0, 4'd0,  4'd0, 0, 4'd0, 0));
      // reti in RUN falls through to increment
      tbl.push_back(mk(0, 0, 0, 4'd0, 1, 0, 4'd0, 4'd1,  4'd0, 0, 4'd0, 0));
      // branch to pc+1 still redirects
      tbl.push_back(mk(0, 0, 1, 4'd2, 0, 0, 4'd0, 4'd2,  4'd0, 0, 4'd0, 1));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

      // Hand sequence: highest line (3) vectors to 15, stall in ISR, wrap, return.
      step(mk(0, 0, 0, 4'd0, 0, 1, 4'b1000, 4'd15, 4'b1000, 1, 4'd3, 1), "irq3_entry");
      step(mk(0, 1, 0, 4'd0, 1, 1, 4'b1000, 4'd15, 4'd0,    1, 4'd3, 0), "isr_stall");
      step(idle(4'd0, 1, 4'd3), "isr_wrap");
      step(mk(0, 0, 0, 4'd0, 1, 0, 4'd0,    4'd3,  4'd0,    0, 4'd3, 1), "irq3_reti");
      step(idle(4'd4, 0, 4'd3), "post_reti");

      // Hand sequence: stall alongside reset, reset still wins.
      step(mk(1, 1, 1, 4'd9, 0, 0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0), "reset_over_stall");
      step(idle(4'd1, 0, 4'd0), "after_reset");

      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
      end
      checks++;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute runtime bound so the bench can never hang.
   initial begin
      #100000;
      $display("FAIL timeout: got no completion, want completion before 100000");
      $fatal(1, "timeout");
   end

endmodule
